bios_watchdog: RTL and testbench

//  BIOS boot watchdog; producer of the ForceSwap[1:0] pulses consumed by the dual-BIOS chip-select logic.
//  - Arms on platform reset release; counts down while BIOS runs POST.
//  - Expiry without a register kick requests a BIOS swap.
//  - Also generates software-forced swap requests.
//  - Sits beside the BIOS select block under ODS_MR and shares the LPC register write bus.

---
 rtl/bios_watchdog_if.sv | 10 +
 rtl/bios_watchdog.sv | 162 ++++++++++++++++
 tb/tb_bios_watchdog.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bios_watchdog_if.sv
// LPC register write bus shared by the BIOS select block and the boot watchdog.
// The master drives one-cycle write strobes; the slave decodes its own addresses.
interface bios_watchdog_if;
  logic       Write;
  logic [7:0] RegAddress;
  logic [7:0] DataWr;

  modport master (output Write, RegAddress, DataWr);
  modport slave  (input  Write, RegAddress, DataWr);
endinterface

// File: rtl/bios_watchdog.sv
// BIOS boot watchdog: arms on platform reset release, counts down in prescaled
// ticks while the BIOS runs POST, and requests a BIOS swap on expiry. Also emits
// software-forced swap pulses. Repeated expiries lock the watchdog until cleared.
// Optional feature macro: BIOSWD_PRETIMEOUT_EN enables the registered pre-timeout
// warning (WdPreWarn / WdStatus[1]); without it both are tied low.
module bios_watchdog #(
  parameter int unsigned PRESCALE        = 3300000,
  parameter logic [7:0]  DEFAULT_TIMEOUT = 8'd150,
  parameter int unsigned MAX_EXPIRE      = 2,
  parameter bit          AUTO_ARM        = 1'b1,
  parameter logic [7:0]  PRE_COUNT       = 8'd10
) (
  input  logic                  LpcClock,
  input  logic                  ResetN,
  input  logic                  MainReset,
  input  logic                  SwapDisable,
  bios_watchdog_if.slave        bus,
  output logic [1:0]            ForceSwap,
  output logic [7:0]            WdStatus,
  output logic [7:0]            WdCount,
  output logic                  WdPreWarn
);

  localparam int unsigned     PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [1:0]      MAX_EXP = 2'(MAX_EXPIRE);

  typedef enum logic [2:0] {
    DISARMED,
    ARMED,
    EXPIRED,
    WAIT_RST,
    LOCKED
  } state_t;

  state_t          state;
  logic            enable;
  logic [7:0]      timeout;
  logic [PS_W-1:0] prescaler;
  logic [1:0]      expire_cnt;
  logic            expired;
  logic            main_q;
  logic            pre_warn;

  // Register decode; writes act on the same edge that samples the strobe, so
  // the FSM looks at the post-write Enable and Timeout values.
  logic       wr_ctrl;
  logic       wr_tmo;
  logic       kick;
  logic       sw_swap;
  logic       clr_status;
  logic       en_next;
  logic [7:0] tmo_next;
  logic       main_rise;
  logic       tick;
  logic [1:0] cnt_inc;

  assign wr_ctrl    = bus.Write && (bus.RegAddress == 8'h05);
  assign wr_tmo     = bus.Write && (bus.RegAddress == 8'h06);
  assign kick       = wr_ctrl && bus.DataWr[1];
  assign sw_swap    = wr_ctrl && bus.DataWr[2];
  assign clr_status = wr_ctrl && bus.DataWr[3];
  assign en_next    = wr_ctrl ? bus.DataWr[0] : enable;
  assign tmo_next   = wr_tmo ? ((bus.DataWr == 8'd0) ? 8'd1 : bus.DataWr) : timeout;
  assign main_rise  = MainReset && !main_q;
  assign tick       = (prescaler == PS_LAST);
  assign cnt_inc    = (expire_cnt == 2'd3) ? 2'd3 : expire_cnt + 2'd1;

  // Watchdog FSM with countdown, status flags and one-cycle swap pulses.
  always_ff @(posedge LpcClock or negedge ResetN) begin
    if (!ResetN) begin
      state      <= DISARMED;
      enable     <= AUTO_ARM;
      timeout    <= DEFAULT_TIMEOUT;
      WdCount    <= DEFAULT_TIMEOUT;
      prescaler  <= '0;
      expire_cnt <= 2'd0;
      expired    <= 1'b0;
      main_q     <= 1'b0;
      ForceSwap  <= 2'b00;
    end else begin
      main_q    <= MainReset;
      enable    <= en_next;
      timeout   <= tmo_next;
      ForceSwap <= {sw_swap, 1'b0};
      case (state)
        DISARMED: begin
          if (en_next && (main_rise || (wr_ctrl && bus.DataWr[0] && MainReset))) begin
            state     <= ARMED;
            prescaler <= '0;
            WdCount   <= tmo_next;
          end
        end
        ARMED: begin
          // Disable, platform reset and kick all pre-empt an expiry in the same cycle.
          if (!en_next) begin
            state <= DISARMED;
          end else if (!MainReset) begin
            state <= WAIT_RST;
          end else if (kick) begin
            prescaler <= '0;
            WdCount   <= tmo_next;
          end else if (tick) begin
            prescaler <= '0;
            if (WdCount <= 8'd1) begin
              WdCount <= 8'd0;
              state   <= EXPIRED;
            end else begin
              WdCount <= WdCount - 8'd1;
            end
          end else begin
            prescaler <= prescaler + PS_W'(1);
          end
        end
        EXPIRED: begin
          ForceSwap <= {sw_swap, !SwapDisable};
          if (clr_status) begin
            state <= WAIT_RST;
          end else begin
            expire_cnt <= cnt_inc;
            expired    <= 1'b1;
            state      <= (cnt_inc >= MAX_EXP) ? LOCKED : WAIT_RST;
          end
        end
        WAIT_RST: begin
          if (!en_next) begin
            state <= DISARMED;
          end else if (main_rise) begin
            state     <= ARMED;
            prescaler <= '0;
            WdCount   <= tmo_next;
          end
        end
        LOCKED: begin
          if (clr_status) state <= DISARMED;
        end
        default: state <= DISARMED;
      endcase
      if (clr_status) begin
        expire_cnt <= 2'd0;
        expired    <= 1'b0;
      end
    end
  end

`ifdef BIOSWD_PRETIMEOUT_EN
  // Pre-timeout warning, registered from the current count.
  always_ff @(posedge LpcClock or negedge ResetN) begin
    if (!ResetN) pre_warn <= 1'b0;
    else         pre_warn <= (state == ARMED) && (WdCount <= PRE_COUNT);
  end
`else
  logic unused_pre_count;
  assign unused_pre_count = ^PRE_COUNT;
  assign pre_warn         = 1'b0;
`endif

  assign WdPreWarn = pre_warn;
  assign WdStatus  = {expire_cnt, (state == LOCKED), expired, (state == ARMED),
                      enable, pre_warn, 1'b0};

endmodule

// File: tb/tb_bios_watchdog.sv
// Bench for bios_watchdog: directed boot/lock/swap/collision scenarios followed by
// randomized register and MainReset traffic, all checked cycle by cycle against a
// deadline-based reference model.
module tb_bios_watchdog;

  localparam int PS   = 4;
  localparam int DTMO = 3;
  localparam int MAXE = 2;
  localparam int PREC = 1;

  logic       LpcClock = 1'b0;
  logic       ResetN;
  logic       MainReset;
  logic       SwapDisable;
  logic [1:0] ForceSwap;
  logic [7:0] WdStatus;
  logic [7:0] WdCount;
  logic       WdPreWarn;

  bios_watchdog_if bus ();

  bios_watchdog #(
    .PRESCALE        (PS),
    .DEFAULT_TIMEOUT (8'(DTMO)),
    .MAX_EXPIRE      (MAXE),
    .AUTO_ARM        (1'b1),
    .PRE_COUNT       (8'(PREC))
  ) dut (
    .LpcClock    (LpcClock),
    .ResetN      (ResetN),
    .MainReset   (MainReset),
    .SwapDisable (SwapDisable),
    .bus         (bus),
    .ForceSwap   (ForceSwap),
    .WdStatus    (WdStatus),
    .WdCount     (WdCount),
    .WdPreWarn   (WdPreWarn)
  );

  always #5 LpcClock = ~LpcClock;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_on = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: the watchdog is described by a reload edge and a deadline
  // (reload + timeout*PS edges); remaining ticks are derived by division.
  int   m_cyc, m_r, m_tl, m_frz, m_tmo, m_cnt;
  bit   m_en, m_run, m_wait, m_lock, m_pend, m_expd, m_mq, m_pw;
  logic [1:0] m_fs;

  function automatic int m_count();
    return m_run ? (m_tl - (m_cyc - m_r) / PS) : m_frz;
  endfunction

  always @(posedge LpcClock) begin
    int  cur, tmo_n;
    bit  wc, wt, en_n, kick, sw, clr, rise, pw_n;
    if (!ResetN) begin
      m_cyc = 0; m_r = 0; m_tl = DTMO; m_frz = DTMO; m_tmo = DTMO; m_cnt = 0;
      m_en = 1'b1; m_run = 0; m_wait = 0; m_lock = 0; m_pend = 0; m_expd = 0;
      m_mq = 0; m_pw = 0; m_fs = 2'b00;
    end else begin
      cur  = m_count();
      pw_n = m_run && (cur <= PREC);
      m_cyc++;
      wc    = bus.Write && (bus.RegAddress == 8'h05);
      wt    = bus.Write && (bus.RegAddress == 8'h06);
      en_n  = wc ? bus.DataWr[0] : m_en;
      tmo_n = wt ? ((bus.DataWr == 8'd0) ? 1 : int'(bus.DataWr)) : m_tmo;
      kick  = wc && bus.DataWr[1];
      sw    = wc && bus.DataWr[2];
      clr   = wc && bus.DataWr[3];
      rise  = MainReset && !m_mq;
      m_fs  = {sw, 1'b0};
      if (m_pend) begin
        m_pend  = 0;
        m_fs[0] = !SwapDisable;
        m_cnt   = (m_cnt < 3) ? m_cnt + 1 : 3;
        m_expd  = 1;
        if (!clr && m_cnt >= MAXE) m_lock = 1;
        else m_wait = 1;
      end else if (m_lock) begin
        if (clr) m_lock = 0;
      end else if (m_run) begin
        if (!en_n) begin
          m_run = 0; m_frz = cur;
        end else if (!MainReset) begin
          m_run = 0; m_wait = 1; m_frz = cur;
        end else if (kick) begin
          m_r = m_cyc; m_tl = tmo_n;
        end else if (m_cyc - m_r == m_tl * PS) begin
          m_run = 0; m_pend = 1; m_frz = 0;
        end
      end else if (m_wait) begin
        if (!en_n) m_wait = 0;
        else if (rise) begin
          m_wait = 0; m_run = 1; m_r = m_cyc; m_tl = tmo_n;
        end
      end else if (en_n && (rise || (wc && bus.DataWr[0] && MainReset))) begin
        m_run = 1; m_r = m_cyc; m_tl = tmo_n;
      end
      if (clr) begin
        m_cnt = 0; m_expd = 0;
      end
      m_en = en_n; m_tmo = tmo_n; m_mq = MainReset;
`ifdef BIOSWD_PRETIMEOUT_EN
      m_pw = pw_n;
`else
      m_pw = 1'b0;
`endif
    end
  end

  // Compare every output against the model away from the active edge.
  always @(negedge LpcClock) begin
    logic [7:0] exp_st;
    if (chk_on) begin
      exp_st = {2'(m_cnt), m_lock, m_expd, m_run, m_en, m_pw, 1'b0};
      check("model_fs", ForceSwap, m_fs);
      check("model_status", WdStatus, exp_st);
      check("model_count", WdCount, m_count());
      check("model_prewarn", WdPreWarn, m_pw);
    end
  end

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    bus.Write = 1'b1; bus.RegAddress = a; bus.DataWr = d;
    @(negedge LpcClock);
    bus.Write = 1'b0;
  endtask

  task automatic boot();
    MainReset = 1'b0;
    @(negedge LpcClock);
    MainReset = 1'b1;
    @(negedge LpcClock);
  endtask

  initial begin
    int first, width, pulses, r;
    logic [7:0] d;
    ResetN = 1'b0; MainReset = 1'b0; SwapDisable = 1'b0;
    bus.Write = 1'b0; bus.RegAddress = 8'h00; bus.DataWr = 8'h00;
    repeat (2) @(negedge LpcClock);

    // T1 reset values
    check("t1_fs", ForceSwap, 2'b00);
    check("t1_status", WdStatus, 8'h04);
    check("t1_count", WdCount, 8'd3);
    chk_on = 1'b1;
    ResetN = 1'b1;
    repeat (2) @(negedge LpcClock);

    // T2 unkicked expiry after arm
    MainReset = 1'b1;
    @(negedge LpcClock);
    first = -1; width = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge LpcClock);
      if (ForceSwap[0]) begin
        width++;
        if (first < 0) first = i;
      end
    end
    check("t2_edge", first, 13);
    check("t2_width", width, 1);
    check("t2_status", WdStatus, 8'h54);

    // T3 regular kicks keep the watchdog quiet
    wr(8'h05, 8'h09);
    boot();
    pulses = 0;
    for (int k = 0; k < 25; k++) begin
      wr(8'h05, 8'h03);
      if (ForceSwap !== 2'b00) pulses++;
      for (int j = 0; j < 7; j++) begin
        @(negedge LpcClock);
        if (ForceSwap !== 2'b00) pulses++;
      end
    end
    check("t3_pulses", pulses, 0);
    check("t3_expired", WdStatus[4], 1'b0);
    check("t3_armed", WdStatus[3], 1'b1);

    // T4 two unkicked boots lock; clear returns to disarmed
    repeat (20) @(negedge LpcClock);
    boot();
    repeat (20) @(negedge LpcClock);
    check("t4_locked", WdStatus, 8'hB4);
    boot();
    repeat (3) @(negedge LpcClock);
    check("t4_no_arm", WdStatus, 8'hB4);
    wr(8'h05, 8'h09);
    check("t4_cleared", WdStatus, 8'h04);

    // T5 software swap pulse, then suppressed expiry swap
    wr(8'h05, 8'h05);
    check("t5_sw_pulse", ForceSwap, 2'b10);
    @(negedge LpcClock);
    check("t5_sw_end", ForceSwap, 2'b00);
    SwapDisable = 1'b1;
    pulses = 0;
    repeat (16) begin
      @(negedge LpcClock);
      if (ForceSwap !== 2'b00) pulses++;
    end
    check("t5_suppressed", pulses, 0);
    check("t5_expired", WdStatus[4], 1'b1);
    SwapDisable = 1'b0;

    // T6 kick on the expiry edge wins
    boot();
    repeat (11) @(negedge LpcClock);
    wr(8'h05, 8'h03);
    check("t6_count", WdCount, 8'd3);
    pulses = 0;
    repeat (8) begin
      @(negedge LpcClock);
      if (ForceSwap !== 2'b00) pulses++;
    end
    check("t6_no_pulse", pulses, 0);

    // Randomized register, platform-reset and swap-disable traffic
    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 99);
      bus.Write = 1'b0;
      if (r < 4) begin
        d = 8'($urandom);
        d[0] = ($urandom_range(0, 9) != 0);
        d[2] = ($urandom_range(0, 3) == 0);
        d[3] = ($urandom_range(0, 4) == 0);
        bus.Write = 1'b1; bus.RegAddress = 8'h05; bus.DataWr = d;
      end else if (r < 6) begin
        bus.Write = 1'b1; bus.RegAddress = 8'h06; bus.DataWr = 8'($urandom_range(0, 6));
      end else if (r < 7) begin
        bus.Write = 1'b1; bus.RegAddress = 8'($urandom); bus.DataWr = 8'($urandom);
      end
      if ($urandom_range(0, 39) == 0) MainReset = ~MainReset;
      if ($urandom_range(0, 63) == 0) SwapDisable = ~SwapDisable;
      @(negedge LpcClock);
    end
    bus.Write = 1'b0;
    @(negedge LpcClock);
    chk_on = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
